// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID pipeline register.
// Follows the hazard unit's PC_write / IFID_write / IF_flush controls and
// runs a BOOT/RUN/STALL FSM whose stall-length counter drives a sticky
// watchdog (StallTimeout).
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating stall/flush
// cycle counters; without it StallCount and FlushCount are tied to 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PC_write,
  input  logic        IFID_write,
  input  logic        IF_flush,
  input  logic        BranchAND,
  input  logic        Jump,
  input  logic        JumpRegister,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JRTarget,
  input  logic [31:0] Instr_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic        StallTimeout,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // MAX_STALL is limited to 1..255, so the 8-bit stall counter covers it.
  localparam logic [7:0] MAX_STALL_W = 8'(MAX_STALL);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [7:0]  stall_len;
  logic [7:0]  stall_len_inc;
  logic        active;
  ifid_t       ifid;

  // BOOT swallows the first edge after reset; every control is ignored there.
  assign active   = (state != BOOT);
  assign pc_plus4 = pc + 32'd4;

  assign stall_len_inc = (stall_len == 8'hFF) ? 8'hFF : stall_len + 8'd1;

  // Redirect priority: jr over j over taken branch over sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (JumpRegister)   next_pc = JRTarget;
    else if (Jump)      next_pc = JumpTarget;
    else if (BranchAND) next_pc = BranchTarget;
  end

  // Fetch FSM, consecutive-stall counter and sticky watchdog.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= BOOT;
      stall_len    <= 8'd0;
      StallTimeout <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (!PC_write && !IFID_write) begin
            state     <= STALL;
            stall_len <= 8'd1;
            if (MAX_STALL_W == 8'd1) StallTimeout <= 1'b1;
          end
        end
        STALL: begin
          if (PC_write) begin
            state     <= RUN;
            stall_len <= 8'd0;
          end else begin
            stall_len <= stall_len_inc;
            if (stall_len_inc == MAX_STALL_W) StallTimeout <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  // PC register: advances only when permitted and out of BOOT.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  pc <= RESET_PC;
    else if (active && PC_write) pc <= next_pc;
  end

  // IF/ID register: flush beats load, load beats hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ifid <= '0;
    end else if (active) begin
      if (IF_flush)        ifid <= '0;
      else if (IFID_write) ifid <= '{instr: Instr_IF, pc4: pc_plus4, valid: 1'b1};
    end
  end

  assign PC_IF          = pc;
  assign Instruction_ID = ifid.instr;
  assign PCPlus4_ID     = ifid.pc4;
  assign Valid_ID       = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Saturating performance counters for stalled and flushed edges.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (active) begin
      if (!PC_write && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (IF_flush && flush_cnt != 32'hFFFF_FFFF)  flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. The driver pushes the
// expected post-edge state from a behavioural model; a monitor pops and
// compares after every rising edge and after each asynchronous reset.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam int          MS  = 4;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        PC_write = 1'b1, IFID_write = 1'b1, IF_flush = 1'b0;
  logic        BranchAND = 1'b0, Jump = 1'b0, JumpRegister = 1'b0;
  logic [31:0] BranchTarget = '0, JumpTarget = '0, JRTarget = '0;
  logic [31:0] Instr_IF;
  logic [31:0] PC_IF, Instruction_ID, PCPlus4_ID, StallCount, FlushCount;
  logic        Valid_ID, StallTimeout;

  always #5 Clk = ~Clk;

  fetch_stage #(.RESET_PC(RPC), .MAX_STALL(MS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .PC_write(PC_write), .IFID_write(IFID_write),
    .IF_flush(IF_flush), .BranchAND(BranchAND), .Jump(Jump),
    .JumpRegister(JumpRegister), .BranchTarget(BranchTarget),
    .JumpTarget(JumpTarget), .JRTarget(JRTarget), .Instr_IF(Instr_IF),
    .PC_IF(PC_IF), .Instruction_ID(Instruction_ID), .PCPlus4_ID(PCPlus4_ID),
    .Valid_ID(Valid_ID), .StallTimeout(StallTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign Instr_IF = imem(PC_IF);

  typedef struct {
    logic [31:0] pc, instr, pc4, sc, fc;
    logic        valid, to;
  } exp_t;

  exp_t q[$];
  event rst_chk;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_sc, m_fc;
  logic        m_valid, m_to, m_boot;
  int          m_len;  // length of the current run of consecutive stalled edges

  function automatic void model_reset();
    m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_to = 0;
    m_sc = 0; m_fc = 0; m_boot = 1; m_len = 0;
  endfunction

  function automatic void model_edge();
    logic [31:0] old_pc;
    if (!Rst_n) begin model_reset(); return; end
    if (m_boot) begin m_boot = 0; return; end
    old_pc = m_pc;
    // A stall run starts when both writes drop, lasts while PC_write stays low.
    if (m_len > 0) begin
      if (PC_write) m_len = 0;
      else if (m_len < 255) m_len = m_len + 1;
    end else if (!PC_write && !IFID_write) begin
      m_len = 1;
    end
    if (m_len == MS) m_to = 1;
    if (IF_flush) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (IFID_write) begin
      m_instr = imem(old_pc); m_pc4 = old_pc + 4; m_valid = 1;
    end
    if (PC_write) begin
      if (JumpRegister)   m_pc = JRTarget;
      else if (Jump)      m_pc = JumpTarget;
      else if (BranchAND) m_pc = BranchTarget;
      else                m_pc = old_pc + 4;
    end
    if (!PC_write && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (IF_flush && m_fc != 32'hFFFF_FFFF)  m_fc = m_fc + 1;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.to = m_to;
`ifdef FETCH_PERF_CNT_EN
    e.sc = m_sc; e.fc = m_fc;
`else
    e.sc = 0; e.fc = 0;
`endif
    q.push_back(e);
  endfunction

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; rn=0 asserts reset (asynchronously if it was high).
  task automatic cycle(input logic rn, input logic pcw, input logic ifw, input logic fl,
                       input logic br, input logic j, input logic jr,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    @(negedge Clk);
    PC_write = pcw; IFID_write = ifw; IF_flush = fl;
    BranchAND = br; Jump = j; JumpRegister = jr;
    BranchTarget = bt; JumpTarget = jt; JRTarget = jrt;
    if (!rn && Rst_n) begin
      Rst_n = 1'b0;
      model_reset();
      push_exp();
      -> rst_chk;
    end
    Rst_n = rn;
    model_edge();
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    @(negedge Clk);
    forever begin
      @(posedge Clk or rst_chk);
      #1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("PC_IF", PC_IF, e.pc);
        chk("Instruction_ID", Instruction_ID, e.instr);
        chk("PCPlus4_ID", PCPlus4_ID, e.pc4);
        chk("Valid_ID", {31'd0, Valid_ID}, {31'd0, e.valid});
        chk("StallTimeout", {31'd0, StallTimeout}, {31'd0, e.to});
        chk("StallCount", StallCount, e.sc);
        chk("FlushCount", FlushCount, e.fc);
      end
    end
  end

  initial begin
    model_reset();
    // reset, release through BOOT, free-run
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // redirect to 0x100, then a two-cycle stall there
    cycle(1, 1, 1, 1, 0, 1, 0, 0, 32'h100, 0);
    stall(2);
    idle(2);
    // jump beats branch, with flush
    cycle(1, 1, 1, 1, 1, 1, 0, 32'h200, 32'h300, 0);
    idle(1);
    // jr beats jump, flush beats IF/ID hold
    cycle(1, 1, 0, 1, 0, 1, 1, 0, 32'h300, 32'h80);
    idle(1);
    // watchdog: five stalled cycles, flag stays after
    stall(5);
    idle(2);
    // async reset in the middle of a stall
    stall(2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // sequential wrap past the top of the address space
    cycle(1, 1, 1, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    idle(3);
    // flush with PC_write low: PC holds, IF/ID bubbles
    cycle(1, 0, 1, 1, 1, 1, 1, 32'h11, 32'h22, 32'h33);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rn, pcw, ifw;
      rn  = ($urandom_range(0, 299) != 0);
      pcw = ($urandom_range(0, 3) != 0);
      ifw = pcw ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      cycle(rn, pcw, ifw, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom, $urandom, $urandom);
    end
    @(posedge Clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
